// File: rtl/amo_arbiter.sv
// Per-unit LR reservations with cross-unit store snooping, plus round-robin
// arbitration of the shared RMW ALU. Optional timeout: AMO_RESERVATION_TIMEOUT_EN.
package amo_pkg;
  typedef enum logic [3:0] {
    AMO_LR   = 4'd0,
    AMO_SC   = 4'd1,
    AMO_SWAP = 4'd2,
    AMO_ADD  = 4'd3,
    AMO_XOR  = 4'd4,
    AMO_AND  = 4'd5,
    AMO_OR   = 4'd6,
    AMO_MIN  = 4'd7,
    AMO_MAX  = 4'd8,
    AMO_MINU = 4'd9,
    AMO_MAXU = 4'd10
  } amo_t;
endpackage

module amo_alu (
  input  amo_pkg::amo_t op,
  input  logic [31:0]   rs1,
  input  logic [31:0]   rs2,
  output logic [31:0]   rd
);
  import amo_pkg::*;

  logic lt_s;
  logic lt_u;

  assign lt_s = $signed(rs1) < $signed(rs2);
  assign lt_u = rs1 < rs2;

  // Result is the value written back to memory; LR passes the loaded word.
  always_comb begin
    rd = rs1;
    case (op)
      AMO_LR:   rd = rs1;
      AMO_SC:   rd = rs2;
      AMO_SWAP: rd = rs2;
      AMO_ADD:  rd = rs1 + rs2;
      AMO_XOR:  rd = rs1 ^ rs2;
      AMO_AND:  rd = rs1 & rs2;
      AMO_OR:   rd = rs1 | rs2;
      AMO_MIN:  rd = lt_s ? rs1 : rs2;
      AMO_MAX:  rd = lt_s ? rs2 : rs1;
      AMO_MINU: rd = lt_u ? rs1 : rs2;
      AMO_MAXU: rd = lt_u ? rs2 : rs1;
      default:  rd = rs1;
    endcase
  end
endmodule

module amo_arbiter #(
  parameter int unsigned NUM_UNITS           = 3,
  parameter int unsigned RESERVATION_WORDS   = 4,
  parameter int unsigned RESERVATION_TIMEOUT = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic          [NUM_UNITS-1:0]        set_reservation,
  input  logic          [NUM_UNITS-1:0]        clear_reservation,
  input  logic          [NUM_UNITS-1:0][31:0]  reservation_addr,
  output logic          [NUM_UNITS-1:0]        reservation_valid,
  input  logic          [NUM_UNITS-1:0]        store_valid,
  input  logic          [NUM_UNITS-1:0][31:0]  store_addr,
  input  logic          [NUM_UNITS-1:0]        rmw_req,
  input  amo_pkg::amo_t [NUM_UNITS-1:0]        rmw_op,
  input  logic          [NUM_UNITS-1:0][31:0]  rmw_rs1,
  input  logic          [NUM_UNITS-1:0][31:0]  rmw_rs2,
  output logic          [NUM_UNITS-1:0]        rmw_gnt,
  output logic                                 rmw_rd_valid,
  output logic          [NUM_UNITS-1:0]        rmw_rd_id,
  output logic          [31:0]                 rmw_rd
);
  import amo_pkg::*;

  localparam int unsigned RW = 30 - $clog2(RESERVATION_WORDS);
  localparam int unsigned PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [NUM_UNITS-1:0]         lr_valid;
  logic [NUM_UNITS-1:0][RW-1:0] lr_addr;
  logic [NUM_UNITS-1:0]         snoop_kill;
  logic [NUM_UNITS-1:0]         timeout_kill;
  logic [NUM_UNITS-1:0]         kill;

  // Reservation match and snoop use the granule-aligned upper address bits.
  always_comb begin
    reservation_valid = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      reservation_valid[i] = lr_valid[i] & (lr_addr[i] == reservation_addr[i][31-:RW]);
    end
  end

  always_comb begin
    snoop_kill = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      for (int unsigned j = 0; j < NUM_UNITS; j++) begin
        if (j != i && store_valid[j] && store_addr[j][31-:RW] == lr_addr[i]) begin
          snoop_kill[i] = 1'b1;
        end
      end
    end
  end

`ifdef AMO_RESERVATION_TIMEOUT_EN
  localparam int unsigned CW = $clog2(RESERVATION_TIMEOUT);

  logic [NUM_UNITS-1:0][CW-1:0] lr_cnt;

  always_comb begin
    timeout_kill = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      timeout_kill[i] = lr_valid[i] & (lr_cnt[i] == CW'(RESERVATION_TIMEOUT - 1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lr_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
        if (set_reservation[i] || !lr_valid[i] || kill[i]) begin
          lr_cnt[i] <= '0;
        end else begin
          lr_cnt[i] <= lr_cnt[i] + CW'(1);
        end
      end
    end
  end
`else
  assign timeout_kill = '0;
`endif

  assign kill = clear_reservation | snoop_kill | timeout_kill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lr_valid <= '0;
      lr_addr  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
        if (set_reservation[i]) begin
          lr_valid[i] <= 1'b1;
          lr_addr[i]  <= reservation_addr[i][31-:RW];
        end else if (kill[i]) begin
          lr_valid[i] <= 1'b0;
        end
      end
    end
  end

  logic [PW-1:0]        ptr;
  logic [NUM_UNITS-1:0] gnt;
  logic [PW-1:0]        gnt_idx;
  logic                 gnt_any;
  int unsigned          cand;

  // First requester at or after ptr, scanning cyclically.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      cand = (32'(ptr) + k) % NUM_UNITS;
      if (!gnt_any && rmw_req[cand]) begin
        gnt_any    = 1'b1;
        gnt[cand]  = 1'b1;
        gnt_idx    = PW'(cand);
      end
    end
  end

  assign rmw_gnt = rst ? gnt : '0;

  amo_t        sel_op;
  logic [31:0] sel_rs1;
  logic [31:0] sel_rs2;
  logic [31:0] alu_rd;

  always_comb begin
    sel_op  = AMO_ADD;
    sel_rs1 = '0;
    sel_rs2 = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (gnt[i]) begin
        sel_op  = rmw_op[i];
        sel_rs1 = rmw_rs1[i];
        sel_rs2 = rmw_rs2[i];
      end
    end
  end

  amo_alu u_alu (
    .op  (sel_op),
    .rs1 (sel_rs1),
    .rs2 (sel_rs2),
    .rd  (alu_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr          <= '0;
      rmw_rd_valid <= 1'b0;
      rmw_rd_id    <= '0;
      rmw_rd       <= '0;
    end else begin
      rmw_rd_valid <= gnt_any;
      if (gnt_any) begin
        ptr       <= PW'((32'(gnt_idx) + 1) % NUM_UNITS);
        rmw_rd_id <= gnt;
        rmw_rd    <= alu_rd;
      end
    end
  end
endmodule
